sparc_exu_ecc_chk_pipe: RTL and testbench
=========================================

# sparc_exu_ecc_chk_pipe

Parametrised, two-stage pipelined SECDED checker/corrector for the EXU register-file read path. It generalises the fixed 64-bit syndrome-to-error-vector decode to any data width. It adds overall-parity double-error detection, a valid/ready handshake with back-pressure, saturating error counters and a first-error syndrome log. It sits between the IRF read port and the bypass/trap logic.

## Interface
- DATA_W, 64, data bits protected; must satisfy 2^(ECC_W-1) - ECC_W >= DATA_W
- ECC_W, 8, check bits: ECC_W-1 Hamming bits plus one overall parity bit (MSB)
- CNT_W, 16, width of each error counter
- rclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chk_en  in  1  1 = check/correct; 0 = bypass (data passed, no flags, no counting)
- in_vld  in  1  input word valid
- in_rdy  out  1  input accepted when in_vld & in_rdy
- in_data  in  DATA_W  stored data
- in_ecc  in  ECC_W  stored check bits
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts when out_vld & out_rdy
- out_data  out  DATA_W  corrected data
- out_ce  out  1  correctable (single-bit) error
- out_ue  out  1  uncorrectable error
- out_synd  out  ECC_W  {parity_mismatch, hamming_syndrome}
- cnt_clr  in  1  clear counters and log
- ce_cnt  out  CNT_W  saturating CE count
- ue_cnt  out  CNT_W  saturating UE count
- log_vld  out  1  first-error log holds an entry
- log_synd  out  ECC_W  syndrome of first logged error
- log_ue  out  1  logged error was UE

## Operation
- Code layout: data bit i occupies Hamming position P(i), the (i+1)-th integer >= 3 that is not a power of two (P(0)=3, P(1)=5, P(4)=9, P(63)=71). Check bit j (j < ECC_W-1) is the XOR of data bits whose P(i) has bit j set. ecc[ECC_W-1] is the XOR of all data bits and ecc[ECC_W-2:0].
- Stage 1 registers: s = recomputed Hamming bits XOR in_ecc[ECC_W-2:0], and p = overall-parity mismatch. Data is registered alongside.
- Stage 2 classifies the error and corrects the data:
  - s=0, p=0: no error.
  - s=0, p=1: parity-bit error. CE; data unchanged.
  - s!=0, p=1, s a power of two: check-bit error. CE; data unchanged.
  - s!=0, p=1, s=P(i) for some i<DATA_W: CE; flip bit i.
  - s!=0, p=1, s not a valid position: UE; data unchanged.
  - s!=0, p=0: double error. UE; data unchanged.
- chk_en is sampled with the data in stage 1 and travels with it. If chk_en=0: out_ce=out_ue=0, out_synd=0, data is unmodified.
- ce_cnt and ue_cnt increment on output transfer (out_vld & out_rdy) with the matching flag set, and saturate at all-ones.
- Log: on the first transfer with out_ce|out_ue while log_vld=0, capture out_synd and out_ue, then set log_vld. Later errors do not overwrite the log.
- cnt_clr: zeroes both counters and log_vld/log_synd/log_ue. If an error transfers in the same cycle as cnt_clr, the clear applies first and the error is then counted and logged: the counter becomes 1 and the log captures the new error.

## Timing
- Latency: 2 cycles from input acceptance to out_vld with no stall. Throughput is 1 word/cycle.
- Stage enables:
  - s2_en = ~out_vld | out_rdy
  - s1_en = ~s1_vld | s2_en
  - in_rdy = s1_en (combinational from out_rdy)
- While out_vld=1 and out_rdy=0, out_data/flags/synd stay stable. No word is dropped or duplicated.
- Reset: s1_vld, out_vld, out_data, out_ce, out_ue, out_synd, counters, log_vld, log_synd and log_ue are all 0. in_rdy is 1 in the first cycle after reset. Words in flight at reset are discarded.
- Counter saturation: at all-ones, a further event holds the value. cnt_clr still clears it.

## Test plan
- DATA_W=64, data=0, ecc=0 on 3 back-to-back cycles -> out_vld in cycles 2,3,4; no flags; counters 0.
- data=64'h1 (bit 0 flipped from a zero codeword), ecc=0 -> out_data=0, out_ce=1, out_synd=8'h83, ce_cnt=1, log_vld=1, log_synd=8'h83.
- bit 63 flipped -> out_synd=8'hC7, corrected to 0. ecc=8'h04 -> CE, synd 8'h84, data unchanged. ecc=8'h80 -> CE, synd 8'h80.
- data=64'h3 (bits 0 and 1 flipped) -> out_ue=1, out_synd=8'h06, data 64'h3 passed, ue_cnt=1.
- Hold out_rdy=0 for 5 cycles with 4 words offered -> 2 accepted, in_rdy=0, outputs stable. Release -> all words out in order.
- CNT_W=2, 5 CE words -> ce_cnt saturates at 3. cnt_clr together with a CE transfer -> ce_cnt=1 and the log holds the new syndrome. Reset mid-stream -> out_vld=0 on the next cycle.

Source files
------------

// File: rtl/sparc_exu_ecc_chk_pipe_if.sv
// sparc_exu_ecc_chk_pipe_if: input/output handshake and data bus of the ECC checker pipe
interface sparc_exu_ecc_chk_pipe_if #(parameter int DATA_W = 64, parameter int ECC_W = 8);
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data;
    logic [ECC_W-1:0]  in_ecc;
    logic              out_vld;
    logic              out_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_ce;
    logic              out_ue;
    logic [ECC_W-1:0]  out_synd;
    modport master (output in_vld, in_data, in_ecc, out_rdy,
                    input  in_rdy, out_vld, out_data, out_ce, out_ue, out_synd);
    modport slave  (input  in_vld, in_data, in_ecc, out_rdy,
                    output in_rdy, out_vld, out_data, out_ce, out_ue, out_synd);
endinterface

// File: rtl/sparc_exu_ecc_chk_pipe.sv
// sparc_exu_ecc_chk_pipe: two-stage SECDED check/correct pipe with error counters and first-error log
module sparc_exu_ecc_chk_pipe #(
    parameter int DATA_W = 64,
    parameter int ECC_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             cnt_clr,
    sparc_exu_ecc_chk_pipe_if.slave bus,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt,
    output logic             log_vld,
    output logic [ECC_W-1:0] log_synd,
    output logic             log_ue
);
    localparam int H = ECC_W - 1;
    // Hamming position of each data bit: the non-power-of-two integers from 3 upward
    function automatic logic [DATA_W*H-1:0] pos_tab();
        logic [DATA_W*H-1:0] t;
        int k;
        t = '0;
        k = 0;
        for (int n = 3; n < (1 << H); n++)
            if ((n & (n - 1)) != 0 && k < DATA_W) begin
                t[k*H +: H] = H'(n);
                k++;
            end
        return t;
    endfunction
    localparam logic [DATA_W*H-1:0] POS = pos_tab();
    logic              s1_vld, s1_chk, s1_p;
    logic [H-1:0]      s1_s;
    logic [DATA_W-1:0] s1_data;
    logic              s1_en, s2_en, xfer;
    logic [H-1:0]      h;
    logic [DATA_W-1:0] mask;
    logic              nz, pow2, hit, ce, ue;
    logic [CNT_W-1:0]  ce_base, ue_base;
    logic              log_base;
    assign s2_en      = ~bus.out_vld | bus.out_rdy;
    assign s1_en      = ~s1_vld | s2_en;
    assign bus.in_rdy = s1_en;
    assign xfer       = bus.out_vld & bus.out_rdy;
    // XOR of the positions of all set data bits equals the Hamming check bits
    always_comb begin
        h = '0;
        for (int i = 0; i < DATA_W; i++) h ^= bus.in_data[i] ? POS[i*H +: H] : '0;
    end
    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W; i++) mask[i] = s1_s == POS[i*H +: H];
    end
    assign nz   = |s1_s;
    assign pow2 = (s1_s & (s1_s - 1'b1)) == '0;
    assign hit  = |mask;
    assign ce   = s1_chk & s1_p & (~nz | pow2 | hit);
    assign ue   = s1_chk & nz & (~s1_p | ~(pow2 | hit));
    // A clear in the same cycle takes effect before the transferring word is counted/logged
    assign ce_base  = cnt_clr ? '0 : ce_cnt;
    assign ue_base  = cnt_clr ? '0 : ue_cnt;
    assign log_base = cnt_clr ? 1'b0 : log_vld;
    always_ff @(posedge rclk) begin
        if (reset) begin
            s1_vld       <= 1'b0;
            s1_chk       <= 1'b0;
            s1_p         <= 1'b0;
            s1_s         <= '0;
            s1_data      <= '0;
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            bus.out_ce   <= 1'b0;
            bus.out_ue   <= 1'b0;
            bus.out_synd <= '0;
            ce_cnt       <= '0;
            ue_cnt       <= '0;
            log_vld      <= 1'b0;
            log_synd     <= '0;
            log_ue       <= 1'b0;
        end else begin
            if (s1_en) s1_vld <= bus.in_vld;
            if (s1_en && bus.in_vld) begin
                s1_chk  <= chk_en;
                s1_s    <= h ^ bus.in_ecc[H-1:0];
                s1_p    <= ^{bus.in_data, bus.in_ecc};
                s1_data <= bus.in_data;
            end
            if (s2_en) bus.out_vld <= s1_vld;
            if (s2_en && s1_vld) begin
                bus.out_data <= s1_data ^ ((s1_chk & s1_p & nz) ? mask : '0);
                bus.out_ce   <= ce;
                bus.out_ue   <= ue;
                bus.out_synd <= s1_chk ? {s1_p, s1_s} : '0;
            end
            ce_cnt <= ce_base + CNT_W'(xfer & bus.out_ce & ~&ce_base);
            ue_cnt <= ue_base + CNT_W'(xfer & bus.out_ue & ~&ue_base);
            if (xfer && (bus.out_ce || bus.out_ue) && !log_base) begin
                log_vld  <= 1'b1;
                log_synd <= bus.out_synd;
                log_ue   <= bus.out_ue;
            end else begin
                log_vld  <= log_base;
                log_synd <= cnt_clr ? '0 : log_synd;
                log_ue   <= cnt_clr ? 1'b0 : log_ue;
            end
        end
    end
endmodule

// File: tb/tb_sparc_exu_ecc_chk_pipe.sv
// tb_sparc_exu_ecc_chk_pipe: directed checks of SECDED decode, handshake, counters and log
module tb_sparc_exu_ecc_chk_pipe;
    logic       clk = 1'b0;
    logic       reset, chk_en, cnt_clr;
    logic [1:0] ce_cnt, ue_cnt;
    logic       log_vld, log_ue;
    logic [7:0] log_synd;
    int         checks = 0;
    int         failures = 0;
    int         idx;
    logic       acc;
    logic [63:0] got[$];
    logic [63:0] v;
    always #5 clk = ~clk;
    sparc_exu_ecc_chk_pipe_if #(.DATA_W(64), .ECC_W(8)) bus ();
    sparc_exu_ecc_chk_pipe #(.DATA_W(64), .ECC_W(8), .CNT_W(2)) dut (
        .rclk(clk), .reset(reset), .chk_en(chk_en), .cnt_clr(cnt_clr), .bus(bus),
        .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .log_vld(log_vld), .log_synd(log_synd), .log_ue(log_ue));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic word(input logic [63:0] d, input logic [7:0] e);
        bus.in_vld = 1'b1; bus.in_data = d; bus.in_ecc = e;
        tick();
        bus.in_vld = 1'b0;
        tick();
    endtask
    initial begin
        reset = 1'b1; chk_en = 1'b1; cnt_clr = 1'b0;
        bus.in_vld = 1'b0; bus.in_data = '0; bus.in_ecc = '0; bus.out_rdy = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_out_vld", 64'(bus.out_vld), 0);
        chk("rst_in_rdy", 64'(bus.in_rdy), 1);
        chk("rst_ce_cnt", 64'(ce_cnt), 0);
        chk("rst_log_vld", 64'(log_vld), 0);
        chk("rst_out_data", bus.out_data, 0);
        tick();
        bus.in_vld = 1'b1;
        tick(); chk("b2b_c1_vld", 64'(bus.out_vld), 0);
        tick(); chk("b2b_c2_vld", 64'(bus.out_vld), 1);
        tick(); bus.in_vld = 1'b0; chk("b2b_c3_vld", 64'(bus.out_vld), 1);
        tick(); chk("b2b_c4_vld", 64'(bus.out_vld), 1);
        chk("b2b_ce", 64'(bus.out_ce | bus.out_ue), 0);
        tick(); chk("b2b_c5_vld", 64'(bus.out_vld), 0);
        chk("b2b_cnt", 64'({ce_cnt, ue_cnt}), 0);
        word(64'h1, 8'h00);
        chk("bit0_data", bus.out_data, 0);
        chk("bit0_ce", 64'({bus.out_ce, bus.out_ue}), 64'b10);
        chk("bit0_synd", 64'(bus.out_synd), 64'h83);
        tick();
        chk("bit0_ce_cnt", 64'(ce_cnt), 1);
        chk("bit0_log", 64'({log_vld, log_ue, log_synd}), {54'd0, 2'b10, 8'h83});
        word(64'h8000_0000_0000_0000, 8'h00);
        chk("bit63_data", bus.out_data, 0);
        chk("bit63_synd", 64'(bus.out_synd), 64'hC7);
        tick();
        chk("bit63_log_keep", 64'(log_synd), 64'h83);
        word(64'h0, 8'h04);
        chk("chk2_ce", 64'({bus.out_ce, bus.out_ue}), 64'b10);
        chk("chk2_synd", 64'(bus.out_synd), 64'h84);
        chk("chk2_data", bus.out_data, 0);
        tick();
        chk("ce_cnt_3", 64'(ce_cnt), 3);
        word(64'h0, 8'h80);
        chk("par_ce", 64'(bus.out_ce), 1);
        chk("par_synd", 64'(bus.out_synd), 64'h80);
        tick();
        word(64'h1, 8'h00);
        tick();
        chk("ce_cnt_sat", 64'(ce_cnt), 3);
        word(64'h3, 8'h00);
        chk("dbl_flags", 64'({bus.out_ce, bus.out_ue}), 64'b01);
        chk("dbl_synd", 64'(bus.out_synd), 64'h06);
        chk("dbl_data", bus.out_data, 64'h3);
        tick();
        chk("dbl_ue_cnt", 64'(ue_cnt), 1);
        chk("dbl_log_ue", 64'(log_ue), 0);
        chk_en = 1'b0;
        word(64'h1, 8'h00);
        chk("byp_data", bus.out_data, 64'h1);
        chk("byp_flags", 64'({bus.out_ce, bus.out_ue, bus.out_synd}), 0);
        tick();
        chk("byp_ue_cnt", 64'(ue_cnt), 1);
        chk_en = 1'b1;
        word(64'h10, 8'h00);
        chk("clr_synd", 64'(bus.out_synd), 64'h89);
        chk("clr_data", bus.out_data, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_ce_cnt", 64'(ce_cnt), 1);
        chk("clr_ue_cnt", 64'(ue_cnt), 0);
        chk("clr_log", 64'({log_vld, log_ue, log_synd}), {54'd0, 2'b10, 8'h89});
        chk_en = 1'b0;
        bus.out_rdy = 1'b0;
        idx = 0; bus.in_vld = 1'b1; bus.in_data = 64'd10;
        for (int c = 0; c < 5; c++) begin
            #1;
            acc = bus.in_vld & bus.in_rdy;
            tick();
            if (acc) begin
                idx++;
                bus.in_data = 64'(10 + idx);
                bus.in_vld = idx < 4;
            end
        end
        #1;
        chk("stall_accepted", 64'(idx), 2);
        chk("stall_in_rdy", 64'(bus.in_rdy), 0);
        chk("stall_out_vld", 64'(bus.out_vld), 1);
        chk("stall_out_data", bus.out_data, 64'd10);
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            #1;
            acc = bus.in_vld & bus.in_rdy;
            if (bus.out_vld) got.push_back(bus.out_data);
            tick();
            if (acc) begin
                idx++;
                bus.in_data = 64'(10 + idx);
                bus.in_vld = idx < 4;
            end
        end
        chk("drain_count", 64'(got.size()), 4);
        for (int i = 0; i < 4; i++) begin
            v = i < got.size() ? got[i] : 'x;
            chk("drain_order", v, 64'(10 + i));
        end
        chk_en = 1'b1;
        bus.in_vld = 1'b1; bus.in_data = 64'h0; bus.in_ecc = 8'h0;
        tick();
        tick();
        chk("mid_out_vld", 64'(bus.out_vld), 1);
        reset = 1'b1;
        bus.in_vld = 1'b0;
        tick();
        chk("mid_rst_vld", 64'(bus.out_vld), 0);
        chk("mid_rst_cnt", 64'({ce_cnt, log_vld}), 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_rdy", 64'(bus.in_rdy), 1);
        tick();
        chk("mid_rst_discard", 64'(bus.out_vld), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
